ro_window_counter: RTL and testbench
====================================

# ro_window_counter

Parametrised, multi-channel successor to the post-mux ring-oscillator counter in the RO-PUF datapath. It counts rising edges of CHANNELS asynchronous ring-oscillator inputs over a programmable window of `clk` cycles. It then latches per-channel counts and produces one PUF response bit per adjacent channel pair. It sits between the RO array/mux stage and the response collection logic, and replaces the fixed 8-bit single-channel counter.

## Interface
- CHANNELS, 2, number of RO inputs counted in parallel; must be even and ≥2.
- CNT_W, 8, width of each per-channel edge counter.
- WIN_W, 16, width of the window-length input.
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ro_in  input  CHANNELS  raw ring-oscillator outputs, asynchronous to clk.
- start  input  1  level-sampled request to begin a measurement.
- window_len  input  WIN_W  counting window in clk cycles; latched on accepted start.
- busy  output  1  high from accepted start until the done cycle; low in the done cycle.
- done  output  1  one-cycle pulse when results become valid.
- finished  output  1  level; high from done until the next accepted start.
- counts  output  CHANNELS*CNT_W  per-channel counts; channel i occupies bits [i*CNT_W +: CNT_W].
- saturated  output  CHANNELS  per-channel overflow flag.
- response  output  CHANNELS/2  response[k] = counts[2k] > counts[2k+1] (unsigned, strict).

## Operation
- Each ro_in bit passes through a 2-FF synchroniser and then an edge register. A rising edge is s2 & ~s3. Countable RO frequency is < clk/2.
- FSM states: IDLE, FLUSH, COUNT, DONE.
- IDLE: if start=1, go to FLUSH. On the same transition, clear counts and saturated, set busy, clear finished, latch window_len into win_cnt.
- FLUSH: lasts exactly 2 cycles. Stale synchroniser contents are discarded and no counting occurs. It exits to COUNT, or to DONE if the latched window_len = 0.
- COUNT: lasts exactly window_len cycles. In each cycle, every channel with a detected rising edge increments by 1. Then go to DONE.
- DONE: lasts 1 cycle. done=1, busy=0, finished set. response is computed from the final counts and registered. Then go to IDLE.
- start is ignored in FLUSH, COUNT and DONE. It is accepted in IDLE only, so a start held high re-arms one cycle after DONE.
- counts, saturated and response hold their values until the next accepted start.
- Equal counts in a pair give response bit 0.

## Timing
- Reset values (asynchronous, on reset_n=0): state=IDLE, busy=0, done=0, finished=0, counts=0, saturated=0, response=0, synchronisers=0.
- start sampled high at edge T gives busy=1 after T.
- The done pulse occurs in cycle T+2+window_len+1 after the start edge.
- Total latency is 3+window_len cycles.
- window_len=0 gives done 3 cycles after start, with all counts 0.
- Reset asserted mid-measurement aborts immediately to reset values. No done pulse is generated for the aborted run.
- The edge-detect register is not cleared at start. An edge straddling the FLUSH→COUNT boundary is counted once.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- POST_MUX_CNT_SAT_EN defined:
  - Counters stop at 2^CNT_W−1.
  - An edge arriving at max sets saturated[i]; the flag stays set until the next start.
- POST_MUX_CNT_SAT_EN undefined:
  - Counters wrap modulo 2^CNT_W.
  - saturated is tied to 0.
  - response compares the wrapped values.

## Test plan
- Defaults; ro_in[0] toggles every 2 clk (rising edge every 4 clk); ro_in[1]=0; window_len=100 → done at start+103, counts[0]=25, counts[1]=0, response=1, finished=1.
- Both channels toggle every 2 clk, window_len=40 → counts[0]=counts[1]=10, response=0.
- ro_in[0] toggles every clk; window_len=1000; CNT_W=8 → with the macro, counts[0]=255 and saturated[0]=1. Without the macro, counts[0]=244 and saturated=0.
- start pulsed again during COUNT → ignored; single done at start+3+window_len; counts unaffected.
- reset_n driven low 20 cycles into a window_len=100 run → all outputs 0 immediately. After release and a fresh start with window_len=0, done occurs 3 cycles later with counts 0.
- CHANNELS=4, channels toggling every 2, 4, 3 and 6 clk, window_len=120 → counts 30,15,20,10; response=2'b11.

Source files
------------

// File: rtl/ro_window_counter_if.sv
// ro_window_counter_if: measurement request / result bundle for the RO window counter.
// master = requester (drives RO inputs and start), slave = the counter block.
interface ro_window_counter_if #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  parameter int WIN_W    = 16
);
  logic [CHANNELS-1:0]       ro_in;
  logic                      start;
  logic [WIN_W-1:0]          window_len;
  logic                      busy;
  logic                      done;
  logic                      finished;
  logic [CHANNELS*CNT_W-1:0] counts;
  logic [CHANNELS-1:0]       saturated;
  logic [CHANNELS/2-1:0]     response;

  modport master (
    output ro_in, start, window_len,
    input  busy, done, finished, counts, saturated, response
  );

  modport slave (
    input  ro_in, start, window_len,
    output busy, done, finished, counts, saturated, response
  );
endinterface

// File: rtl/ro_window_counter.sv
// ro_window_counter: counts rising edges on CHANNELS async RO inputs over a
// window of clk cycles, then latches counts and one response bit per pair.
// Optional feature macro: POST_MUX_CNT_SAT_EN (saturating counters + flags);
// without it counters wrap and saturated is tied low.

// Per-channel synchroniser, edge detect and counter.
module ro_window_counter_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ro,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  logic s1, s2, s3;
  logic rise;

  // 2-FF synchroniser plus edge register; never cleared by start so an edge
  // straddling the flush/count boundary is seen exactly once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ro;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

`ifdef POST_MUX_CNT_SAT_EN
  // Saturating counter: an edge arriving at all-ones raises the sticky flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (en && rise) begin
      if (&cnt) sat <= 1'b1;
      else      cnt <= cnt + 1'b1;
    end
  end
`else
  // Wrapping counter (modulo 2^CNT_W).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (en && rise)  cnt <= cnt + 1'b1;
  end

  assign sat = 1'b0;
`endif
endmodule

module ro_window_counter #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  parameter int WIN_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ro_window_counter_if.slave    bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                     state;
  logic [WIN_W-1:0]               win_cnt;
  logic                           flush_cnt;
  logic                           busy_q, done_q, fin_q;
  logic [CHANNELS/2-1:0]          resp_q, resp_next;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_l;
  logic [CHANNELS-1:0]            sat_l;
  logic                           clr, en;

  assign clr = (state == S_IDLE) && bus.start;
  assign en  = (state == S_COUNT);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    ro_window_counter_lane #(.CNT_W(CNT_W)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .ro      (bus.ro_in[i]),
      .clr     (clr),
      .en      (en),
      .cnt     (cnt_l[i]),
      .sat     (sat_l[i])
    );
  end

  // One response bit per adjacent pair; ties resolve to 0.
  for (genvar k = 0; k < CHANNELS/2; k++) begin : g_resp
    assign resp_next[k] = cnt_l[2*k] > cnt_l[2*k+1];
  end

  // Measurement sequencer: IDLE -> FLUSH(2) -> COUNT(window_len) -> DONE(1).
  // done/busy/finished/response update on the edge leaving DONE, so the
  // done pulse lands 3+window_len cycles after the accepting edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      win_cnt   <= '0;
      flush_cnt <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fin_q     <= 1'b0;
      resp_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_FLUSH;
            busy_q    <= 1'b1;
            fin_q     <= 1'b0;
            win_cnt   <= bus.window_len;
            flush_cnt <= 1'b0;
          end
        end
        S_FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) state <= (win_cnt == '0) ? S_DONE : S_COUNT;
        end
        S_COUNT: begin
          win_cnt <= win_cnt - 1'b1;
          if (win_cnt == WIN_W'(1)) state <= S_DONE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          fin_q  <= 1'b1;
          resp_q <= resp_next;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.finished  = fin_q;
  assign bus.counts    = cnt_l;
  assign bus.saturated = sat_l;
  assign bus.response  = resp_q;
endmodule

// File: tb/tb_ro_window_counter.sv
// tb_ro_window_counter: scoreboard bench. Expected results are pushed when a
// start is driven and compared when done pulses.
module tb_ro_window_counter;
  localparam int CH = 4;
  localparam int CW = 8;
  localparam int WW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ro_window_counter_if #(.CHANNELS(CH), .CNT_W(CW), .WIN_W(WW)) bus();

  ro_window_counter #(.CHANNELS(CH), .CNT_W(CW), .WIN_W(WW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int                dcyc;
    logic [CH*CW-1:0]  cnt;
    logic [CH-1:0]     sat;
    logic [CH/2-1:0]   resp;
  } exp_t;

  exp_t sbq[$];
  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int half [CH] = '{default: 0};
  int ph   [CH] = '{default: 0};
  logic [CH*CW-1:0] obs_cnt;
  logic [CH-1:0]    obs_sat;
  logic [CH/2-1:0]  obs_resp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Analytic model: a square wave with half-period h gives one rising edge
  // per 2h cycles; windows are chosen as exact multiples of every period.
  function automatic exp_t model(input int w, input int dcyc);
    exp_t e;
    int ed;
    e.dcyc = dcyc;
    e.cnt  = '0;
    e.sat  = '0;
    e.resp = '0;
    for (int i = 0; i < CH; i++) begin
      ed = (half[i] == 0) ? 0 : w / (2 * half[i]);
`ifdef POST_MUX_CNT_SAT_EN
      if (ed > (1 << CW) - 1) begin
        e.cnt[i*CW +: CW] = '1;
        e.sat[i] = 1'b1;
      end else e.cnt[i*CW +: CW] = ed[CW-1:0];
`else
      e.cnt[i*CW +: CW] = ed[CW-1:0];
`endif
    end
    for (int k = 0; k < CH/2; k++)
      e.resp[k] = e.cnt[2*k*CW +: CW] > e.cnt[(2*k+1)*CW +: CW];
    return e;
  endfunction

  // RO stimulus: each channel toggles every half[i] clk, away from the edge.
  initial begin
    bus.ro_in = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < CH; i++) begin
        if (half[i] != 0) begin
          ph[i]++;
          if (ph[i] >= half[i]) begin
            ph[i] = 0;
            bus.ro_in[i] = ~bus.ro_in[i];
          end
        end
      end
    end
  end

  // Done monitor: every done pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.done) begin
        if (sbq.size() == 0) chk("spurious_done", 1'b1, 1'b0);
        else begin
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.dcyc);
          chk("counts", bus.counts, e.cnt);
          chk("saturated", bus.saturated, e.sat);
          chk("response", bus.response, e.resp);
          chk("busy_in_done", bus.busy, 1'b0);
          chk("finished_in_done", bus.finished, 1'b1);
          obs_cnt  = bus.counts;
          obs_sat  = bus.saturated;
          obs_resp = bus.response;
        end
      end
    end
  end

  task automatic set_ro(input int h0, input int h1, input int h2, input int h3);
    half[0] = h0; half[1] = h1; half[2] = h2; half[3] = h3;
    repeat (20) @(negedge clk);
  endtask

  task automatic run(input int w);
    @(negedge clk);
    bus.start = 1'b1;
    bus.window_len = w[WW-1:0];
    sbq.push_back(model(w, cyc + 1 + 3 + w));
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1'b1);
    chk("finished_cleared", bus.finished, 1'b0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", sbq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.window_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_finished", bus.finished, 1'b0);
    chk("rst_counts", bus.counts, '0);
    chk("rst_saturated", bus.saturated, '0);
    chk("rst_response", bus.response, '0);
    reset_n = 1'b1;

    // single oscillating channel
    set_ro(2, 0, 0, 0);
    run(100);
    wait_done(150);
    chk("tp1_cnt0", obs_cnt[7:0], 8'd25);
    chk("tp1_cnt1", obs_cnt[15:8], 8'd0);
    chk("tp1_resp0", obs_resp[0], 1'b1);
    repeat (3) @(negedge clk);
    chk("finished_hold", bus.finished, 1'b1);
    chk("counts_hold", bus.counts, obs_cnt);
    chk("response_hold", bus.response, obs_resp);

    // equal pair -> response 0
    set_ro(2, 2, 0, 0);
    run(40);
    wait_done(80);
    chk("tp2_cnt0", obs_cnt[7:0], 8'd10);
    chk("tp2_cnt1", obs_cnt[15:8], 8'd10);
    chk("tp2_resp0", obs_resp[0], 1'b0);

    // overflow: 500 edges into an 8-bit counter
    set_ro(1, 0, 0, 0);
    run(1000);
    wait_done(1100);
`ifdef POST_MUX_CNT_SAT_EN
    chk("tp3_cnt0", obs_cnt[7:0], 8'd255);
    chk("tp3_sat0", obs_sat[0], 1'b1);
`else
    chk("tp3_cnt0", obs_cnt[7:0], 8'd244);
    chk("tp3_sat", obs_sat, '0);
`endif

    // start pulsed mid-count must be ignored
    set_ro(2, 0, 0, 0);
    run(60);
    repeat (20) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(100);
    chk("tp4_cnt0", obs_cnt[7:0], 8'd15);

    // reset mid-measurement aborts without a done pulse
    run(100);
    repeat (20) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_finished", bus.finished, 1'b0);
    chk("abort_counts", bus.counts, '0);
    chk("abort_saturated", bus.saturated, '0);
    chk("abort_response", bus.response, '0);
    sbq.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (110) @(negedge clk);
    run(0);
    wait_done(10);
    chk("tp5_counts", obs_cnt, '0);

    // four channels at different rates
    set_ro(2, 4, 3, 6);
    run(120);
    wait_done(160);
    chk("tp6_cnt0", obs_cnt[7:0], 8'd30);
    chk("tp6_cnt1", obs_cnt[15:8], 8'd15);
    chk("tp6_cnt2", obs_cnt[23:16], 8'd20);
    chk("tp6_cnt3", obs_cnt[31:24], 8'd10);
    chk("tp6_resp", obs_resp, 2'b11);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
